mux_seq_ctrl: RTL

Parametrised one-hot phase sequencer driving the segment-select multiplexers of the BSCAC codec datapath. It generalises the fixed 3-phase free-running ring to N phases, with a programmable dwell per phase, counted or continuous runs, stall, and abort. It reports completion with a start/busy/done handshake. It sits between the codec control logic and the encoder/decoder segment muxes.

---
 rtl/mux_seq_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mux_seq_ctrl.sv
// mux_seq_ctrl: N-phase one-hot sequencer for the BSCAC segment-select muxes.
// Inputs:  clk, rst_n, start, cont, dwell_cfg, rounds_cfg, en, abort
// Outputs: ctrl_flags (one-hot select), phase_idx, flag_valid, busy,
//          last_phase, done (one-cycle completion pulse)
module mux_seq_ctrl #(
  parameter  int N_PHASE = 3,
  parameter  int DWELL_W = 4,
  parameter  int ROUND_W = 8,
  localparam int PIDX_W  = $clog2(N_PHASE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell_cfg,
  input  logic [ROUND_W-1:0] rounds_cfg,
  input  logic               en,
  input  logic               abort,
  output logic [N_PHASE-1:0] ctrl_flags,
  output logic [PIDX_W-1:0]  phase_idx,
  output logic               flag_valid,
  output logic               busy,
  output logic               last_phase,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [N_PHASE-1:0] FLAGS_INIT = N_PHASE'(1);
  localparam logic [PIDX_W-1:0]  IDX_LAST   = PIDX_W'(N_PHASE - 1);
  localparam logic [PIDX_W-1:0]  IDX_PRE    = PIDX_W'(N_PHASE - 2);

  state_t             state;
  logic [DWELL_W-1:0] dwell_q;
  logic [ROUND_W-1:0] rounds_q;
  logic               cont_q;
  logic [DWELL_W-1:0] dcnt;
  logic [ROUND_W-1:0] rcnt;

  logic dwell_end;
  logic at_last_idx;
  logic enter_last;

  always_comb begin
    dwell_end   = (dcnt == dwell_q);
    at_last_idx = (phase_idx == IDX_LAST);
    // last_phase is registered, so it is set on the advance into phase
    // N_PHASE-1 of the final round (round counter only moves on wrap).
    enter_last  = !cont_q && (phase_idx == IDX_PRE) && (rcnt == rounds_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dwell_q    <= '0;
      rounds_q   <= '0;
      cont_q     <= 1'b0;
      dcnt       <= '0;
      rcnt       <= '0;
      ctrl_flags <= FLAGS_INIT;
      phase_idx  <= '0;
      flag_valid <= 1'b0;
      busy       <= 1'b0;
      last_phase <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= RUN;
            dwell_q    <= dwell_cfg;
            rounds_q   <= rounds_cfg;
            cont_q     <= cont;
            dcnt       <= '0;
            rcnt       <= '0;
            ctrl_flags <= FLAGS_INIT;
            phase_idx  <= '0;
            flag_valid <= 1'b1;
            busy       <= 1'b1;
            last_phase <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            ctrl_flags <= FLAGS_INIT;
            phase_idx  <= '0;
            flag_valid <= 1'b0;
            busy       <= 1'b0;
            last_phase <= 1'b0;
          end else if (en) begin
            if (!dwell_end) begin
              dcnt <= dcnt + DWELL_W'(1);
            end else begin
              dcnt <= '0;
              // last_phase already encodes "final phase of final round".
              if (last_phase) begin
                state      <= IDLE;
                ctrl_flags <= FLAGS_INIT;
                phase_idx  <= '0;
                flag_valid <= 1'b0;
                busy       <= 1'b0;
                last_phase <= 1'b0;
                done       <= 1'b1;
              end else begin
                ctrl_flags <= {ctrl_flags[N_PHASE-2:0], ctrl_flags[N_PHASE-1]};
                if (at_last_idx) begin
                  phase_idx <= '0;
                  rcnt      <= rcnt + ROUND_W'(1);
                end else begin
                  phase_idx <= phase_idx + PIDX_W'(1);
                end
                last_phase <= enter_last;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
